debug_ctrl: RTL
===============

DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 SHALL have parameter NUM_BP, default 4, number of hardware PC breakpoints (1..16).
REQ-002 SHALL have parameter ADDR_W, default 32, PC and breakpoint address width.
REQ-003 SHALL have parameter STEP_W, default 16, step-count and steps_done width.
REQ-004 SHALL have parameter WDOG_W, default 20, watchdog counter width.
REQ-005 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port cmd_valid  in  1  command request.
REQ-008 SHALL have port cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
REQ-009 SHALL have port cmd_op  in  3  opcode: NOP=0, RUN=1, STEPI=2, STEPN=3, BP_SET=4, BP_CLR=5, ABORT=6.
REQ-010 SHALL have port cmd_arg  in  STEP_W  step count for STEPN.
REQ-011 SHALL have port bp_idx  in  $clog2(NUM_BP), minimum 1  breakpoint slot for BP_SET/BP_CLR.
REQ-012 SHALL have port bp_addr  in  ADDR_W  breakpoint address for BP_SET.
REQ-013 SHALL have port pc  in  ADDR_W  CPU next-fetch address.
REQ-014 SHALL have ports instruction_retired, finish_exec_signal, unrecognised_opcode_flag  in  1 each  CPU status.
REQ-015 SHALL have ports cpu_halt  out  1; cmd_done  out  1 (one-cycle pulse); exit_signal  out  1 (sticky).
REQ-016 SHALL have ports stop_reason  out  3 (NONE=0, STEP=1, BP=2, EXIT=3, ILLEGAL=4, ABORT=5, WDOG=6) and steps_done  out  STEP_W.

Function
REQ-017 SHALL implement states IDLE, RUN, STEP, DONE; cpu_halt=1 in IDLE and DONE, 0 in RUN and STEP.
REQ-018 SHALL drive cmd_ready=1 in IDLE for any op; in RUN/STEP only when cmd_op=ABORT; 0 in DONE.
REQ-019 SHALL, on accepting RUN in IDLE, enter RUN next cycle; on STEPI, enter STEP with target 1; on STEPN, enter STEP with target cmd_arg, where 0 is treated as 1.
REQ-020 SHALL clear steps_done on accepting RUN/STEPI/STEPN and increment it per retired instruction, saturating at all-ones.
REQ-021 SHALL execute BP_SET (slot bp_idx: address=bp_addr, enabled) and BP_CLR (slot disabled) in the accept cycle; index >= NUM_BP is ignored; DONE follows with reason NONE.
REQ-022 SHALL treat NOP and undefined opcodes as accepted, no effect, DONE with reason NONE.
REQ-023 SHALL flag a breakpoint hit in RUN/STEP when instruction_retired=1 and pc equals any enabled slot address, so resuming from a breakpoint PC does not re-fire.
REQ-024 SHALL flag STEP completion when the retire count reaches the target in STEP.
REQ-025 SHALL, when any stop event occurs in cycle M, enter DONE at M+1 with cmd_done=1 and stop_reason latched, then IDLE at M+2.
REQ-026 SHALL resolve simultaneous stop events by priority EXIT > ILLEGAL > ABORT > BP > STEP > WDOG.
REQ-027 SHALL set exit_signal on finish_exec_signal in RUN/STEP and hold it until reset; afterwards RUN/STEPI/STEPN SHALL go straight to DONE with reason EXIT.
REQ-028 SHALL hold stop_reason stable from DONE until the next accepted command.

Reset
REQ-029 SHALL, while reset_n=0 at a clk edge, set state IDLE, cpu_halt=1, cmd_done=0, exit_signal=0, stop_reason=NONE, steps_done=0, all breakpoint slots disabled; reset mid-RUN aborts without a cmd_done pulse.

Configuration
REQ-030 SHALL, with DEBUG_CTRL_WATCHDOG_EN defined, count cycles in RUN/STEP since the last retire, clear it on retire or entry, and raise a WDOG stop at 2^WDOG_W-1.
REQ-031 SHALL, without DEBUG_CTRL_WATCHDOG_EN, contain no watchdog counter and never report WDOG.

Structure
REQ-032 SHALL import from package debug_pkg the cmd_op enum, stop_reason enum and state enum.
REQ-033 SHALL place the breakpoint register bank and comparators in sub-module debug_bp_match (parameters NUM_BP, ADDR_W; output hit).

Verification
REQ-034 SHALL test STEPN arg=3 with one retire every 2 cycles -> cmd_done after 3rd retire, steps_done=3, stop_reason=STEP.
REQ-035 SHALL test BP_SET idx=1 addr=0x40, RUN, retire with pc=0x40 -> halt next cycle, reason BP; RUN again and retire with pc=0x44 -> no re-fire.
REQ-036 SHALL test, in RUN, finish_exec_signal and a breakpoint hit in the same cycle -> reason EXIT, exit_signal=1; later STEPI -> immediate DONE with reason EXIT.
REQ-037 SHALL test ABORT issued during RUN -> cmd_ready=1 that cycle, reason ABORT, cpu_halt=1 next cycle.
REQ-038 SHALL test, with WDOG_W=4 and the macro defined, RUN with no retires -> reason WDOG after 15 cycles; without the macro -> remains in RUN.
REQ-039 SHALL test reset_n low for one cycle mid-STEPN -> IDLE, breakpoints cleared, no cmd_done.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types for the debug controller: command opcodes, stop reasons, FSM states.
// Also provides the breakpoint-index width helper used by the interface and the modules.
package debug_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_RUN    = 3'd1,
        OP_STEPI  = 3'd2,
        OP_STEPN  = 3'd3,
        OP_BP_SET = 3'd4,
        OP_BP_CLR = 3'd5,
        OP_ABORT  = 3'd6
    } cmd_op_e;

    typedef enum logic [2:0] {
        SR_NONE    = 3'd0,
        SR_STEP    = 3'd1,
        SR_BP      = 3'd2,
        SR_EXIT    = 3'd3,
        SR_ILLEGAL = 3'd4,
        SR_ABORT   = 3'd5,
        SR_WDOG    = 3'd6
    } stop_reason_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Slot index width, never narrower than one bit.
    function automatic int idx_w(input int num_bp);
        return (num_bp > 1) ? $clog2(num_bp) : 1;
    endfunction

endpackage

// File: rtl/debug_ctrl_if.sv
// Command bus of the debug controller: valid/ready handshake plus opcode and operands.
// The debugger host drives it through the master modport; the controller uses slave.
interface debug_ctrl_if import debug_pkg::*; #(
    parameter int NUM_BP = 4,
    parameter int ADDR_W = 32,
    parameter int STEP_W = 16
) ();
    localparam int IDX_W = idx_w(NUM_BP);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [STEP_W-1:0] cmd_arg;
    logic [IDX_W-1:0]  bp_idx;
    logic [ADDR_W-1:0] bp_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, bp_idx, bp_addr,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, bp_idx, bp_addr,
        output cmd_ready
    );
endinterface

// File: rtl/debug_bp_match.sv
// Hardware PC breakpoint bank: NUM_BP address slots with enable bits and parallel comparators.
// hit is the raw match of pc against any enabled slot; the caller qualifies it with retirement.
module debug_bp_match import debug_pkg::*; #(
    parameter int NUM_BP = 4,
    parameter int ADDR_W = 32,
    localparam int IDX_W = idx_w(NUM_BP)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              set_en,
    input  logic              clr_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] pc,
    output logic              hit
);
    localparam logic [IDX_W:0] NUM_SLOTS = (IDX_W + 1)'(NUM_BP);

    logic [NUM_BP-1:0] slot_en;
    logic [ADDR_W-1:0] slot_addr [NUM_BP];
    logic              idx_ok;

    assign idx_ok = ({1'b0, idx} < NUM_SLOTS);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_en <= '0;
        end else if ((set_en || clr_en) && idx_ok) begin
            slot_en[idx] <= set_en;
        end
    end

    // NOTE: the address array carries no reset; a slot's address is only looked at
    // while its enable bit is set, and enables are what reset clears.
    always_ff @(posedge clk) begin
        if (set_en && idx_ok) begin
            slot_addr[idx] <= addr;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (slot_en[i] && (slot_addr[i] == pc)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_ctrl.sv
// CPU debug controller: run/step/breakpoint command FSM with prioritised stop reasons.
// Define DEBUG_CTRL_WATCHDOG_EN to add a no-retire watchdog that stops execution with WDOG.
module debug_ctrl import debug_pkg::*; #(
    parameter int NUM_BP = 4,
    parameter int ADDR_W = 32,
    parameter int STEP_W = 16,
    parameter int WDOG_W = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    debug_ctrl_if.slave       cmd,
    input  logic [ADDR_W-1:0] pc,
    input  logic              instruction_retired,
    input  logic              finish_exec_signal,
    input  logic              unrecognised_opcode_flag,
    output logic              cpu_halt,
    output logic              cmd_done,
    output logic              exit_signal,
    output logic [2:0]        stop_reason,
    output logic [STEP_W-1:0] steps_done
);
    if (NUM_BP < 1 || NUM_BP > 16 || WDOG_W < 2) begin : g_bad_param
        $error("debug_ctrl: parameter out of range");
    end

    state_e            state_q, state_d;
    stop_reason_e      reason_q, reason_d, stop_code;
    logic [STEP_W-1:0] steps_q, target_q, target_d;
    logic              exit_q;
    logic              active, retire, bp_raw, step_hit, wdog_hit;
    logic              start, bp_set, bp_clr, stop;

    assign active = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign retire = active && instruction_retired;

    debug_bp_match #(.NUM_BP(NUM_BP), .ADDR_W(ADDR_W)) u_bp (
        .clk     (clk),
        .reset_n (reset_n),
        .set_en  (bp_set),
        .clr_en  (bp_clr),
        .idx     (cmd.bp_idx),
        .addr    (cmd.bp_addr),
        .pc      (pc),
        .hit     (bp_raw)
    );

    // Target is never zero, so the subtraction cannot wrap.
    assign step_hit = (state_q == ST_STEP) && retire && (steps_q == target_q - STEP_W'(1));

`ifdef DEBUG_CTRL_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_q;

    always_ff @(posedge clk) begin
        if (!reset_n || !active || retire) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
        end
    end

    assign wdog_hit = active && (wdog_q == '1);
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        stop      = 1'b1;
        stop_code = SR_NONE;
        if (finish_exec_signal)                              stop_code = SR_EXIT;
        else if (unrecognised_opcode_flag)                   stop_code = SR_ILLEGAL;
        else if (cmd.cmd_valid && (cmd.cmd_op == OP_ABORT))  stop_code = SR_ABORT;
        else if (retire && bp_raw)                           stop_code = SR_BP;
        else if (step_hit)                                   stop_code = SR_STEP;
        else if (wdog_hit)                                   stop_code = SR_WDOG;
        else                                                 stop      = 1'b0;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        reason_d      = reason_q;
        target_d      = target_q;
        cmd.cmd_ready = 1'b0;
        start         = 1'b0;
        bp_set        = 1'b0;
        bp_clr        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    state_d  = ST_DONE;
                    reason_d = SR_NONE;
                    case (cmd.cmd_op)
                        OP_RUN, OP_STEPI, OP_STEPN: begin
                            start    = 1'b1;
                            target_d = STEP_W'(1);
                            if (cmd.cmd_op == OP_STEPN && cmd.cmd_arg != '0) target_d = cmd.cmd_arg;
                            // Once the program has exited, execution requests bounce straight back.
                            if (exit_q)                       reason_d = SR_EXIT;
                            else if (cmd.cmd_op == OP_RUN)    state_d  = ST_RUN;
                            else                              state_d  = ST_STEP;
                        end
                        OP_BP_SET: bp_set = 1'b1;
                        OP_BP_CLR: bp_clr = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RUN, ST_STEP: begin
                cmd.cmd_ready = (cmd.cmd_op == OP_ABORT);
                if (stop) begin
                    state_d  = ST_DONE;
                    reason_d = stop_code;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            reason_q <= SR_NONE;
            steps_q  <= '0;
            target_q <= STEP_W'(1);
            exit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reason_q <= reason_d;
            target_q <= target_d;
            if (start) begin
                steps_q <= '0;
            end else if (retire && (steps_q != '1)) begin
                steps_q <= steps_q + STEP_W'(1);
            end
            if (active && finish_exec_signal) exit_q <= 1'b1;
        end
    end

    assign cpu_halt    = !active;
    assign cmd_done    = (state_q == ST_DONE);
    assign exit_signal = exit_q;
    assign stop_reason = reason_q;
    assign steps_done  = steps_q;

endmodule
